// File: rtl/sbox_bist.sv
// Built-in self-test for an AES S-box / InvSbox pair: sweeps all 256 bytes through S then InvS.
// Define SBOX_BIST_KAT_EN to also check four known-answer entries of the forward S-box.
module sbox_bist #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       encrypt,
    output logic [7:0] byte_in,
    input  logic [7:0] byte_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] fail_byte,
    output logic [7:0] fail_data,
    output logic       fail_kat
);

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        INV,
        FINISH
    } state_t;

    localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [7:0] x;

`ifdef SBOX_BIST_KAT_EN
    logic       kat_hit;
    logic [7:0] kat_exp;
    logic       kat_bad;
    logic       fail_kat_r;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        kat_hit = 1'b1;
        kat_exp = 8'h00;
        case (x)
            8'h00:   kat_exp = 8'h63;
            8'h01:   kat_exp = 8'h7C;
            8'h53:   kat_exp = 8'hED;
            8'hFF:   kat_exp = 8'h16;
            default: kat_hit = 1'b0;
        endcase
    end

    assign kat_bad  = kat_hit && (byte_out != kat_exp);
    assign fail_kat = fail_kat_r;
`else
    assign fail_kat = 1'b0;
`endif

    // During INV, byte_in already holds the forward result y, so no separate y register.
    // NOTE: all state below is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            x         <= '0;
            encrypt   <= 1'b1;
            byte_in   <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_byte <= 8'h00;
            fail_data <= 8'h00;
`ifdef SBOX_BIST_KAT_EN
            fail_kat_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FWD;
                        cnt       <= '0;
                        x         <= 8'h00;
                        encrypt   <= 1'b1;
                        byte_in   <= 8'h00;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail_byte <= 8'h00;
                        fail_data <= 8'h00;
`ifdef SBOX_BIST_KAT_EN
                        fail_kat_r <= 1'b0;
`endif
                    end
                end

                FWD: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
`ifdef SBOX_BIST_KAT_EN
                        if (kat_bad) begin
                            state      <= FINISH;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            pass       <= 1'b0;
                            encrypt    <= 1'b1;
                            byte_in    <= 8'h00;
                            fail_byte  <= x;
                            fail_data  <= byte_out;
                            fail_kat_r <= 1'b1;
                        end else
`endif
                        begin
                            state   <= INV;
                            encrypt <= 1'b0;
                            byte_in <= byte_out;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                INV: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (byte_out != x) begin
                            state     <= FINISH;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= 1'b0;
                            encrypt   <= 1'b1;
                            byte_in   <= 8'h00;
                            fail_byte <= x;
                            fail_data <= byte_out;
                        end else if (x == 8'hFF) begin
                            state   <= FINISH;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= 1'b1;
                            encrypt <= 1'b1;
                            byte_in <= 8'h00;
                        end else begin
                            state   <= FWD;
                            x       <= x + 8'd1;
                            encrypt <= 1'b1;
                            byte_in <= x + 8'd1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                FINISH: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_bist.sv
// Self-checking bench for sbox_bist: one DUT with SETTLE_CYCLES=1 and a combinational
// S-box model, one with SETTLE_CYCLES=3 and a registered model; faults are planted in the tables.
module tb_sbox_bist;

`ifdef SBOX_BIST_KAT_EN
    localparam bit KAT = 1'b1;
`else
    localparam bit KAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic [1:0]      start_v;
    wire  [1:0]      enc_v;
    wire  [1:0][7:0] bi_v;
    wire  [1:0]      busy_v;
    wire  [1:0]      done_v;
    wire  [1:0]      pass_v;
    wire  [1:0][7:0] fb_v;
    wire  [1:0][7:0] fd_v;
    wire  [1:0]      kat_v;
    logic [7:0]      bo0;
    logic [7:0]      bo1;

    logic [7:0] aes_s[256];
    logic [7:0] aes_i[256];
    logic [7:0] sb[256];
    logic [7:0] ib[256];

    int checks = 0;
    int errors = 0;

    sbox_bist #(.SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .encrypt(enc_v[0]),
        .byte_in(bi_v[0]), .byte_out(bo0), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .fail_byte(fb_v[0]), .fail_data(fd_v[0]), .fail_kat(kat_v[0])
    );

    sbox_bist #(.SETTLE_CYCLES(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .encrypt(enc_v[1]),
        .byte_in(bi_v[1]), .byte_out(bo1), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .fail_byte(fb_v[1]), .fail_data(fd_v[1]), .fail_kat(kat_v[1])
    );

    assign bo0 = enc_v[0] ? sb[bi_v[0]] : ib[bi_v[0]];
    always @(posedge clk) bo1 <= enc_v[1] ? sb[bi_v[1]] : ib[bi_v[1]];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [7:0] r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // AES S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_aes();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            aes_s[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int a = 0; a < 256; a++) aes_i[aes_s[a]] = 8'(a);
    endtask

    // 0 clean, 1 InvS(0x63)=0x01, 2 S(0)/S(1) swapped with matching inverse,
    // 3 one random inverse entry corrupted, 4 one random forward entry corrupted.
    task automatic set_mode(input int m);
        int r;
        logic [7:0] k;
        for (int i = 0; i < 256; i++) begin
            sb[i] = aes_s[i];
            ib[i] = aes_i[i];
        end
        r = $urandom_range(0, 255);
        k = 8'($urandom_range(1, 255));
        case (m)
            1: ib[8'h63] = 8'h01;
            2: begin
                sb[8'h00] = 8'h7C; sb[8'h01] = 8'h63;
                ib[8'h7C] = 8'h00; ib[8'h63] = 8'h01;
            end
            3: ib[aes_s[r]] = 8'(r) ^ k;
            4: sb[r] = aes_s[r] ^ k;
            default: ;
        endcase
    endtask

    // Walk the sweep as the rules describe it and predict the final report and busy time.
    task automatic ref_sweep(input int settle, output int cyc, output bit p,
                             output logic [7:0] fb, output logic [7:0] fd, output bit k);
        cyc = 512 * settle; p = 1'b1; fb = 8'h00; fd = 8'h00; k = 1'b0;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] y = sb[x];
            logic [7:0] z;
            bit kat_fail = 1'b0;
            if (KAT) begin
                if (x == 8'h00 && y != 8'h63) kat_fail = 1'b1;
                if (x == 8'h01 && y != 8'h7C) kat_fail = 1'b1;
                if (x == 8'h53 && y != 8'hED) kat_fail = 1'b1;
                if (x == 8'hFF && y != 8'h16) kat_fail = 1'b1;
            end
            if (kat_fail) begin
                cyc = (2 * x + 1) * settle; p = 1'b0; fb = 8'(x); fd = y; k = 1'b1;
                return;
            end
            z = ib[y];
            if (z != 8'(x)) begin
                cyc = (2 * x + 2) * settle; p = 1'b0; fb = 8'(x); fd = z; k = 1'b0;
                return;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input int d, input string name);
        check({name, "_busy"}, busy_v[d], 0);
        check({name, "_done"}, done_v[d], 0);
        check({name, "_pass"}, pass_v[d], 0);
        check({name, "_fb"}, fb_v[d], 0);
        check({name, "_fd"}, fd_v[d], 0);
        check({name, "_kat"}, kat_v[d], 0);
        check({name, "_enc"}, enc_v[d], 1);
        check({name, "_bi"}, bi_v[d], 0);
    endtask

    task automatic run_sweep(input int d, input bit spam, input int exp_cyc, input bit exp_p,
                             input logic [7:0] exp_fb, input logic [7:0] exp_fd,
                             input bit exp_k, input string name);
        int cyc = 0;
        @(negedge clk) start_v[d] = 1'b1;
        @(negedge clk) start_v[d] = 1'b0;
        while (busy_v[d] === 1'b1 && cyc < 3000) begin
            cyc++;
            start_v[d] = spam && (cyc % 50 == 0);
            @(negedge clk);
        end
        start_v[d] = 1'b0;
        check({name, "_busy_cycles"}, cyc, exp_cyc);
        check({name, "_done"}, done_v[d], 1);
        check({name, "_pass"}, pass_v[d], exp_p);
        check({name, "_fail_byte"}, fb_v[d], exp_fb);
        check({name, "_fail_data"}, fd_v[d], exp_fd);
        check({name, "_fail_kat"}, kat_v[d], exp_k);
        check({name, "_finish_enc"}, enc_v[d], 1);
        check({name, "_finish_bi"}, bi_v[d], 0);
        @(negedge clk);
        check({name, "_idle_busy"}, busy_v[d], 0);
        check({name, "_idle_done_held"}, done_v[d], 1);
        check({name, "_idle_pass_held"}, pass_v[d], exp_p);
    endtask

    typedef struct {
        int         mode;
        int         dut;
        bit         spam;
        int         cyc;
        bit         p;
        logic [7:0] fb;
        logic [7:0] fd;
        bit         k;
        string      name;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0, 0, 1'b0, 512, 1'b1, 8'h00, 8'h00, 1'b0, "clean_s1"};
        vecs[1] = '{1, 0, 1'b0, 2, 1'b0, 8'h00, 8'h01, 1'b0, "inv63_s1"};
        vecs[2] = KAT ? '{2, 0, 1'b0, 1, 1'b0, 8'h00, 8'h7C, 1'b1, "swap01_s1"}
                      : '{2, 0, 1'b0, 512, 1'b1, 8'h00, 8'h00, 1'b0, "swap01_s1"};
        vecs[3] = '{0, 0, 1'b1, 512, 1'b1, 8'h00, 8'h00, 1'b0, "start_spam_s1"};
        vecs[4] = '{0, 1, 1'b1, 1536, 1'b1, 8'h00, 8'h00, 1'b0, "clean_s3"};
        vecs[5] = '{1, 1, 1'b0, 6, 1'b0, 8'h00, 8'h01, 1'b0, "inv63_s3"};

        build_aes();
        set_mode(0);
        start_v = 2'b00;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state(0, "por0");
        check_reset_state(1, "por1");
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_no_start", busy_v[0], 0);

        for (int i = 0; i < 6; i++) begin
            set_mode(vecs[i].mode);
            run_sweep(vecs[i].dut, vecs[i].spam, vecs[i].cyc, vecs[i].p,
                      vecs[i].fb, vecs[i].fd, vecs[i].k, vecs[i].name);
        end

        // Reset from IDLE after a failing sweep clears the sticky report.
        set_mode(1);
        run_sweep(0, 1'b0, 2, 1'b0, 8'h00, 8'h01, 1'b0, "pre_reset_fail");
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_reset_state(0, "reset_after_fail");

        // Mid-sweep reset at busy cycle 100, with a simultaneous start that must be dropped.
        set_mode(0);
        @(negedge clk) start_v[0] = 1'b1;
        @(negedge clk) start_v[0] = 1'b0;
        check("fwd0_enc", enc_v[0], 1);
        check("fwd0_bi", bi_v[0], 8'h00);
        @(negedge clk);
        check("inv0_enc", enc_v[0], 0);
        check("inv0_bi", bi_v[0], 8'h63);
        @(negedge clk);
        check("fwd1_bi", bi_v[0], 8'h01);
        repeat (97) @(negedge clk);
        check("busy_at_100", busy_v[0], 1);
        reset_n = 1'b0;
        start_v[0] = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        start_v[0] = 1'b0;
        check_reset_state(0, "mid_reset");
        @(negedge clk);
        check("reset_start_dropped", busy_v[0], 0);
        run_sweep(0, 1'b0, 512, 1'b1, 8'h00, 8'h00, 1'b0, "after_reset");

        // Randomised faults against the reference walk.
        for (int i = 0; i < 6; i++) begin
            int d = $urandom_range(0, 1);
            int cyc;
            bit p;
            bit k;
            logic [7:0] fb;
            logic [7:0] fd;
            set_mode($urandom_range(3, 4));
            ref_sweep(d ? 3 : 1, cyc, p, fb, fd, k);
            run_sweep(d, 1'b0, cyc, p, fb, fd, k, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
